// File: rtl/gp_fifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter sharing one gp_fifo write port among N_REQ sources.
// A source owns the port from its first flit through its last flit; writes stall on fifo_full.
module gp_fifo_wr_arbiter #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IDX_W  = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ-1:0]        req_last,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    fifo_write_en,
    output logic [DATA_W-1:0]       fifo_data_in,
    input  logic                    fifo_full,
    input  logic                    fifo_error,
    output logic [N_REQ-1:0]        grant,
    output logic                    busy,
    output logic [CNT_W-1:0]        pkt_cnt,
    output logic                    err_sticky
);

    typedef enum logic {StIdle, StLocked} state_e;

    state_e           state;
    logic [IDX_W-1:0] gnt_idx;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] winner;
    logic             locked;
    logic             owner_valid;
    logic             owner_last;
    logic             accept;
    int               cand;

    // Scan from the highest offset down so the closest valid index to rr_ptr wins.
    always_comb begin
        winner = rr_ptr;
        cand   = 0;
        for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
            cand = int'(rr_ptr) + k;
            if (cand >= int'(N_REQ)) begin
                cand = cand - int'(N_REQ);
            end
            if (req_valid[cand]) begin
                winner = IDX_W'(cand);
            end
        end
    end

    assign locked      = (state == StLocked);
    assign owner_valid = req_valid[gnt_idx];
    assign owner_last  = req_last[gnt_idx];
    assign accept      = locked && owner_valid && !fifo_full;

    always_comb begin
        grant         = '0;
        req_ready     = '0;
        fifo_write_en = 1'b0;
        fifo_data_in  = '0;
        busy          = locked;
        if (locked) begin
            grant[gnt_idx]     = 1'b1;
            req_ready[gnt_idx] = !fifo_full;
            fifo_write_en      = accept;
            fifo_data_in       = req_data[gnt_idx*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StIdle;
            gnt_idx    <= '0;
            rr_ptr     <= '0;
            pkt_cnt    <= '0;
            err_sticky <= 1'b0;
        end else begin
            if (fifo_error) begin
                err_sticky <= 1'b1;
            end
            unique case (state)
                StIdle: begin
                    if (|req_valid) begin
                        gnt_idx <= winner;
                        state   <= StLocked;
                    end
                end
                StLocked: begin
                    if (accept && owner_last) begin
                        state   <= StIdle;
                        pkt_cnt <= pkt_cnt + 1'b1;
                        if (int'(gnt_idx) == int'(N_REQ) - 1) begin
                            rr_ptr <= '0;
                        end else begin
                            rr_ptr <= gnt_idx + 1'b1;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
